// File: rtl/end_screen_sequencer.sv
// End-screen sequencer: fades a face glyph in, holds it for a number of
// frames, then waits for a fresh jump-button press and pulses restart.
// MODE selects the glyph set (0 = frown drawn in red, 1 = smile drawn in green).
// Optional feature macro: END_SCREEN_BLINK_EN makes the glyph blink while armed.
module end_screen_sequencer #(
   parameter int MODE          = 0,
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int BLOCK_WIDTH   = 40,
   parameter int GRID_COLS     = 17,
   parameter int GRID_ROWS     = 12,
   parameter int HOLD_FRAMES   = 120,
   parameter int BLINK_FRAMES  = 30
) (
   input  logic        vga_clock,
   input  logic        reset,
   input  logic        start,
   input  logic        jump_button,
   input  logic [31:0] row,
   input  logic [31:0] column,
   input  logic        display_enable,
   output logic [3:0]  vga_red,
   output logic [3:0]  vga_green,
   output logic [3:0]  vga_blue,
   output logic [9:0]  leds,
   output logic        busy,
   output logic        restart
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FADE  = 3'd1,
      HOLD  = 3'd2,
      ARMED = 3'd3,
      EXIT  = 3'd4
   } state_t;

   localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);

   // A blink half-period of zero would never toggle; reject it at elaboration.
   if (BLINK_FRAMES < 1) begin : g_bad_blink
      $error("BLINK_FRAMES must be at least 1");
   end

   // The glyph ROM holds a 12 x 17 face; tiles outside it are background.
   // Row strings read left to right, column 0 first.
   function automatic logic glyph_at(input logic [3:0] ty, input logic [4:0] tx);
      logic [16:0] r;
      logic [16:0] s;
      case (ty)
         4'd1, 4'd2: r = 17'b00011100000111000;
         4'd6:       r = (MODE == 0) ? 17'b00000011111000000 : 17'b00001000000010000;
         4'd7:       r = 17'b00000100000100000;
         4'd8:       r = (MODE == 0) ? 17'b00001000000010000 : 17'b00000011111000000;
         default:    r = '0;
      endcase
      s = r << tx;
      return s[16];
   endfunction

   state_t            state_q, state_d;
   logic [3:0]        intensity_q, intensity_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              sync1_q, sync2_q, prev_q;
   logic [3:0]        red_q, green_q, blue_q;
   logic [3:0]        red_d, green_d, blue_d;
   logic              frame_tick;
   logic              press;
   logic              glyph_vis;

`ifdef END_SCREEN_BLINK_EN
   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES + 1) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               visible_q, visible_d;
`endif

   assign frame_tick = display_enable
                    && (row == 32'(SCREEN_HEIGHT - 1))
                    && (column == 32'(SCREEN_WIDTH - 1));

   // A press is a rising edge of the synchronised button.
   assign press = sync2_q & ~prev_q;

   // Two-flop synchroniser for the raw button plus the edge-detect history flop.
   always_ff @(posedge vga_clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= jump_button;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Sequencer state, fade intensity and frame counters.
   always_ff @(posedge vga_clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         intensity_q <= 4'd0;
         hold_cnt_q  <= '0;
`ifdef END_SCREEN_BLINK_EN
         blink_cnt_q <= '0;
         visible_q   <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         intensity_q <= intensity_d;
         hold_cnt_q  <= hold_cnt_d;
`ifdef END_SCREEN_BLINK_EN
         blink_cnt_q <= blink_cnt_d;
         visible_q   <= visible_d;
`endif
      end
   end

   // Next-state logic; every state change restarts the frame counters.
   always_comb begin
      state_d     = state_q;
      intensity_d = intensity_q;
      hold_cnt_d  = hold_cnt_q;
`ifdef END_SCREEN_BLINK_EN
      blink_cnt_d = blink_cnt_q;
      visible_d   = visible_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = FADE;
               intensity_d = 4'd0;
            end
         end
         FADE: begin
            if (frame_tick) begin
               if (intensity_q == 4'd15) state_d = HOLD;
               else intensity_d = intensity_q + 4'd1;
            end
         end
         HOLD: begin
            if (HOLD_FRAMES == 0) begin
               state_d = ARMED;
            end else if (frame_tick) begin
               if (hold_cnt_q == HOLD_LAST) state_d = ARMED;
               else hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         ARMED: begin
            if (press) state_d = EXIT;
`ifdef END_SCREEN_BLINK_EN
            if (frame_tick) begin
               if (blink_cnt_q == BLINK_LAST) begin
                  blink_cnt_d = '0;
                  visible_d   = ~visible_q;
               end else begin
                  blink_cnt_d = blink_cnt_q + BLINK_W'(1);
               end
            end
`endif
         end
         EXIT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) begin
         hold_cnt_d  = '0;
`ifdef END_SCREEN_BLINK_EN
         blink_cnt_d = '0;
         visible_d   = 1'b1;
`endif
      end
   end

`ifdef END_SCREEN_BLINK_EN
   assign glyph_vis = (state_q != ARMED) || visible_q;
`else
   assign glyph_vis = 1'b1;
`endif

   // Pixel colour for the current row/column, registered below.
   always_comb begin
      logic [31:0] tx;
      logic [31:0] ty;
      logic        in_map;
      logic        pix_on;
      tx     = column / BLOCK_WIDTH;
      ty     = row / BLOCK_WIDTH;
      in_map = (tx < GRID_COLS) && (ty < GRID_ROWS) && (tx < 32'd17) && (ty < 32'd12);
      pix_on = display_enable && (state_q != IDLE) && in_map && glyph_vis
            && glyph_at(ty[3:0], tx[4:0]);
      red_d   = (MODE == 0 && pix_on) ? intensity_q : 4'd0;
      green_d = (MODE != 0 && pix_on) ? intensity_q : 4'd0;
      blue_d  = 4'd0;
   end

   // Colour output registers give one cycle of latency from the pixel inputs.
   always_ff @(posedge vga_clock or posedge reset) begin
      if (reset) begin
         red_q   <= 4'd0;
         green_q <= 4'd0;
         blue_q  <= 4'd0;
      end else begin
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
      end
   end

   assign vga_red   = red_q;
   assign vga_green = green_q;
   assign vga_blue  = blue_q;
   assign leds      = {2'b00, sync2_q, intensity_q, state_q};
   assign busy      = (state_q != IDLE);
   assign restart   = (state_q == EXIT);

endmodule
